stack_alu_unit: RTL and testbench

- Parametrised successor to the fixed 4-bit push/pop stack register.
- A WIDTH-bit, DEPTH-entry LIFO data stack with an integrated op port. Supported ops: push, pop, dup, swap, over, add, sub.
- Tracks occupancy, with full/empty flags, sticky overflow/underflow errors and an add/sub carry.
- Sits between the op decoder and the memory/output mux of the stack CPU. TOS/NOS feed RAM data-in and the output mux.

---
 rtl/stack_alu_unit.sv | 135 +++++++++++++
 tb/tb_stack_alu_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/stack_alu_unit.sv
// WIDTH-bit, DEPTH-entry LIFO data stack with push/pop/dup/swap/over/add/sub,
// occupancy tracking, sticky overflow/underflow flags and an add/sub carry.
module stack_alu_unit #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    depth,
  output logic             empty,
  output logic             full,
  output logic             carry,
  output logic             err_ovf,
  output logic             err_udf
);

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_DUP  = 3'd3,
    OP_SWAP = 3'd4,
    OP_OVER = 3'd5,
    OP_ADD  = 3'd6,
    OP_SUB  = 3'd7
  } op_e;

  logic [WIDTH-1:0] e     [DEPTH];
  logic [WIDTH-1:0] e_nxt [DEPTH];
  logic [CW-1:0]    depth_q, depth_nxt;
  logic             carry_q, carry_nxt;
  logic             err_ovf_q, err_udf_q;
  logic [1:0]       need;
  logic             grows, udf, ovf, exec;
  logic [WIDTH:0]   res;
  op_e              op_c;

  // Result MSB is the carry for ADD and the borrow for SUB (nos - tos).
  function automatic logic [WIDTH:0] alu_result(input logic sub,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    if (sub) return {1'b0, a} - {1'b0, b};
    else     return {1'b0, a} + {1'b0, b};
  endfunction

  assign op_c = op_e'(op);

  always_comb begin
    need  = 2'd0;
    grows = 1'b0;
    case (op_c)
      OP_PUSH: grows = 1'b1;
      OP_POP:  need  = 2'd1;
      OP_DUP:  begin need = 2'd1; grows = 1'b1; end
      OP_SWAP: need  = 2'd2;
      OP_OVER: begin need = 2'd2; grows = 1'b1; end
      OP_ADD,
      OP_SUB:  need  = 2'd2;
      default: ;
    endcase
    // Underflow wins over overflow; either one suppresses the op entirely.
    udf  = op_valid && (depth_q < CW'(need));
    ovf  = op_valid && !udf && grows && (depth_q == CW'(DEPTH));
    exec = op_valid && (op_c != OP_NOP) && !udf && !ovf;
  end

  always_comb begin
    e_nxt     = e;
    depth_nxt = depth_q;
    carry_nxt = carry_q;
    res       = alu_result(op_c == OP_SUB, e[1], e[0]);
    if (exec) begin
      case (op_c)
        OP_PUSH, OP_DUP, OP_OVER: begin
          for (int i = DEPTH - 1; i > 0; i--) e_nxt[i] = e[i-1];
          if (op_c == OP_PUSH)     e_nxt[0] = din;
          else if (op_c == OP_DUP) e_nxt[0] = e[0];
          else                     e_nxt[0] = e[1];
          depth_nxt = depth_q + CW'(1);
        end
        OP_POP: begin
          for (int i = 0; i < DEPTH - 1; i++) e_nxt[i] = e[i+1];
          e_nxt[DEPTH-1] = '0;
          depth_nxt = depth_q - CW'(1);
        end
        OP_SWAP: begin
          e_nxt[0] = e[1];
          e_nxt[1] = e[0];
        end
        OP_ADD, OP_SUB: begin
          e_nxt[0] = res[WIDTH-1:0];
          for (int i = 1; i < DEPTH - 1; i++) e_nxt[i] = e[i+1];
          e_nxt[DEPTH-1] = '0;
          carry_nxt = res[WIDTH];
          depth_nxt = depth_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) e[i] <= '0;
      depth_q   <= '0;
      carry_q   <= 1'b0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      e         <= e_nxt;
      depth_q   <= depth_nxt;
      carry_q   <= carry_nxt;
      // A new error in the same cycle as clr_err still lands.
      err_ovf_q <= ovf || (err_ovf_q && !clr_err);
      err_udf_q <= udf || (err_udf_q && !clr_err);
    end
  end

  assign tos     = e[0];
  assign nos     = e[1];
  assign depth   = depth_q;
  assign empty   = (depth_q == '0);
  assign full    = (depth_q == CW'(DEPTH));
  assign carry   = carry_q;
  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;

endmodule

// File: tb/tb_stack_alu_unit.sv
// Bench for stack_alu_unit: directed scenarios plus random ops checked
// against a queue-based stack model.
module tb_stack_alu_unit;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, DUP = 3'd3,
                         SWAP = 3'd4, OVER = 3'd5, ADD = 3'd6, SUB = 3'd7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             op_valid = 1'b0;
  logic [2:0]       op = 3'd0;
  logic [WIDTH-1:0] din = '0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] tos, nos;
  logic [CW-1:0]    depth;
  logic             empty, full, carry, err_ovf, err_udf;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: q[0] is the top of stack.
  int q[$];
  bit m_carry, m_ovf, m_udf;

  stack_alu_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .din(din),
    .clr_err(clr_err), .tos(tos), .nos(nos), .depth(depth), .empty(empty),
    .full(full), .carry(carry), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_carry = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic model_step(input logic [2:0] o, input int d, input bit v, input bit c);
    int  need = 0;
    bit  grows = 0;
    bit  u, ov;
    int  a, b, t;
    case (o)
      PUSH: grows = 1;
      POP:  need = 1;
      DUP:  begin need = 1; grows = 1; end
      SWAP: need = 2;
      OVER: begin need = 2; grows = 1; end
      ADD, SUB: need = 2;
      default: ;
    endcase
    u  = v && (q.size() < need);
    ov = v && !u && grows && (q.size() == DEPTH);
    if (v && !u && !ov) begin
      case (o)
        PUSH: q.push_front(d);
        POP:  void'(q.pop_front());
        DUP:  q.push_front(q[0]);
        SWAP: begin t = q[0]; q[0] = q[1]; q[1] = t; end
        OVER: q.push_front(q[1]);
        ADD: begin
          a = q.pop_front(); b = q.pop_front();
          q.push_front((b + a) % 16);
          m_carry = (b + a) >= 16;
        end
        SUB: begin
          a = q.pop_front(); b = q.pop_front();
          q.push_front((b - a + 16) % 16);
          m_carry = b < a;
        end
        default: ;
      endcase
    end
    m_udf = u || (m_udf && !c);
    m_ovf = ov || (m_ovf && !c);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".tos"},   32'(tos),   q.size() > 0 ? q[0] : 0);
    check({tag, ".nos"},   32'(nos),   q.size() > 1 ? q[1] : 0);
    check({tag, ".depth"}, 32'(depth), q.size());
    check({tag, ".empty"}, 32'(empty), q.size() == 0);
    check({tag, ".full"},  32'(full),  q.size() == DEPTH);
    check({tag, ".carry"}, 32'(carry), m_carry);
    check({tag, ".ovf"},   32'(err_ovf), m_ovf);
    check({tag, ".udf"},   32'(err_udf), m_udf);
  endtask

  task automatic do_op(input logic [2:0] o, input int d, input bit v, input bit c);
    @(negedge clk);
    op_valid = v; op = o; din = WIDTH'(d); clr_err = c;
    @(posedge clk);
    model_step(o, d, v, c);
    #1;
    op_valid = 1'b0; clr_err = 1'b0;
    check_all("op");
  endtask

  task automatic drain();
    while (q.size() > 0) do_op(POP, 0, 1, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    check("reset.empty_c", 32'(empty), 1);
    rst = 1'b0;

    // Basic add
    do_op(PUSH, 3, 1, 0); do_op(PUSH, 5, 1, 0); do_op(ADD, 0, 1, 0);
    check("add1.tos", 32'(tos), 8); check("add1.depth", 32'(depth), 1);
    check("add1.carry", 32'(carry), 0); check("add1.nos", 32'(nos), 0);
    drain();

    // Add with carry out
    do_op(PUSH, 9, 1, 0); do_op(PUSH, 7, 1, 0); do_op(ADD, 0, 1, 0);
    check("add2.tos", 32'(tos), 0); check("add2.carry", 32'(carry), 1);
    drain();

    // Subtract with borrow
    do_op(PUSH, 2, 1, 0); do_op(PUSH, 5, 1, 0); do_op(SUB, 0, 1, 0);
    check("sub.tos", 32'(tos), 'hD); check("sub.carry", 32'(carry), 1);
    drain();

    // Swap / over / dup
    do_op(PUSH, 'hA, 1, 0); do_op(PUSH, 1, 1, 0); do_op(SWAP, 0, 1, 0);
    check("swap.tos", 32'(tos), 'hA); check("swap.nos", 32'(nos), 1);
    do_op(OVER, 0, 1, 0);
    check("over.tos", 32'(tos), 1); check("over.depth", 32'(depth), 3);
    do_op(DUP, 0, 1, 0);
    check("dup.tos", 32'(tos), 1); check("dup.nos", 32'(nos), 1);
    check("dup.depth", 32'(depth), 4);
    drain();

    // Fill to full, then overflow
    for (int i = 1; i <= 8; i++) do_op(PUSH, i, 1, 0);
    check("fill.full", 32'(full), 1); check("fill.tos", 32'(tos), 8);
    do_op(PUSH, 9, 1, 0);
    check("ovf.flag", 32'(err_ovf), 1); check("ovf.tos", 32'(tos), 8);
    check("ovf.depth", 32'(depth), 8);
    for (int i = 0; i < 8; i++) do_op(POP, 0, 1, 0);
    check("drain.empty", 32'(empty), 1); check("drain.tos", 32'(tos), 0);

    // Underflow and clear
    do_op(POP, 0, 1, 0);
    check("udf.flag", 32'(err_udf), 1); check("udf.depth", 32'(depth), 0);
    do_op(NOP, 0, 1, 1);
    check("clr.udf", 32'(err_udf), 0); check("clr.ovf", 32'(err_ovf), 0);

    // Clear racing a new error: new error wins
    do_op(SWAP, 0, 1, 1);
    check("clrrace.udf", 32'(err_udf), 1);
    do_op(NOP, 0, 0, 1);

    // Asynchronous reset mid-sequence
    do_op(PUSH, 4, 1, 0); do_op(PUSH, 6, 1, 0);
    @(negedge clk);
    op_valid = 1'b1; op = PUSH; din = 4'hF;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("arst");
    op_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    check_all("arst_rel");

    // Random ops against the model
    for (int n = 0; n < 800; n++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) o = PUSH;
      do_op(o, $urandom_range(0, 15), $urandom_range(0, 7) != 0,
            $urandom_range(0, 15) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
